// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction memory and
// fills the IF/ID register, with a one-entry skid buffer for words that return under stall.
module if_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        j_ctrl,
  input  logic [15:0] j_pc,
  input  logic        hlt,
  output logic        im_re,
  output logic [15:0] im_addr,
  input  logic        im_valid,
  input  logic [15:0] im_rdata,
  output logic [15:0] instr,
  output logic [15:0] pc,
  output logic        instr_valid,
  output logic        halted,
  output logic [1:0]  dbg_state_o
);

  // Memory handshake: im_re is a single-cycle request carrying im_addr; the memory
  // answers with one im_valid pulse some cycles later. At most one request is outstanding.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic        squash_q, squash_d;
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_addr_q, skid_addr_d;
  logic [15:0] ifid_instr_q, ifid_instr_d;
  logic [15:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        im_re_c;
  logic [15:0] im_addr_c;
  logic        halt_req;
  logic        redirect;

  assign halt_req = hlt && !stall;
  assign redirect = j_ctrl && !stall;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    squash_d     = squash_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    im_re_c      = 1'b0;
    im_addr_c    = pc_q;

    // Any non-stalled cycle that does not deliver a word inserts a bubble.
    if (!stall) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end

    unique case (state_q)
      S_FETCH: begin
        if (halt_req) begin
          state_d      = S_HALT;
          skid_valid_d = 1'b0;
        end else if (redirect) begin
          pc_d         = j_pc;
          skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
          if (!stall) begin
            ifid_instr_d = skid_instr_q;
            ifid_pc_d    = skid_addr_q + 16'd1;
            ifid_valid_d = 1'b1;
            pc_d         = skid_addr_q + 16'd1;
            skid_valid_d = 1'b0;
          end
        end else begin
          im_re_c   = 1'b1;
          im_addr_c = pc_q;
          addr_d    = pc_q;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        if (halt_req) begin
          state_d      = S_HALT;
          squash_d     = 1'b0;
          skid_valid_d = 1'b0;
        end else if (redirect) begin
          // A word returning in the same cycle as the jump is dropped outright;
          // otherwise the in-flight response is marked to be dropped on arrival.
          pc_d         = j_pc;
          skid_valid_d = 1'b0;
          if (im_valid) begin
            state_d  = S_FETCH;
            squash_d = 1'b0;
          end else begin
            squash_d = 1'b1;
          end
        end else if (im_valid && squash_q) begin
          state_d  = S_FETCH;
          squash_d = 1'b0;
        end else if (im_valid) begin
          if (stall) begin
            skid_valid_d = 1'b1;
            skid_instr_d = im_rdata;
            skid_addr_d  = addr_q;
            state_d      = S_FETCH;
          end else begin
            ifid_instr_d = im_rdata;
            ifid_pc_d    = addr_q + 16'd1;
            ifid_valid_d = 1'b1;
            pc_d         = addr_q + 16'd1;
            im_re_c      = 1'b1;
            im_addr_c    = addr_q + 16'd1;
            addr_d       = addr_q + 16'd1;
          end
        end
      end

      S_HALT: begin
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
        skid_valid_d = 1'b0;
        squash_d     = 1'b0;
      end

      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      squash_q     <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_addr_q  <= 16'h0000;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 16'h0000;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      squash_q     <= squash_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_addr_q  <= skid_addr_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign im_re       = rst_n && im_re_c;
  assign im_addr     = im_addr_c;
  assign instr       = ifid_instr_q;
  assign pc          = ifid_pc_q;
  assign instr_valid = ifid_valid_q;
  assign halted      = (state_q == S_HALT);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: latency-programmable memory model, scoreboard of {instr, pc}
// consumed by ID on every non-stalled edge, and scenario tasks run in sequence.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        j_ctrl;
  logic [15:0] j_pc;
  logic        hlt;
  logic        im_re;
  logic [15:0] im_addr;
  logic        im_valid;
  logic [15:0] im_rdata;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        instr_valid;
  logic        halted;
  logic [1:0]  dbg_state;

  if_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .j_ctrl      (j_ctrl),
    .j_pc        (j_pc),
    .hlt         (hlt),
    .im_re       (im_re),
    .im_addr     (im_addr),
    .im_valid    (im_valid),
    .im_rdata    (im_rdata),
    .instr       (instr),
    .pc          (pc),
    .instr_valid (instr_valid),
    .halted      (halted),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  bit          sb_en;
  int          lat;
  bit          pend;
  int          cnt;
  logic [15:0] paddr;
  logic [15:0] s_instr, s_pc, s_addr;
  logic        s_valid, s_re, s_halted;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  function automatic void push_exp(input logic [15:0] a);
    logic [15:0] nxt;
    nxt = a + 16'd1;
    exp_q.push_back({mem_f(a), nxt});
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    logic [31:0] e;
    im_valid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        im_valid = 1'b1;
        im_rdata = mem_f(paddr);
        pend     = 1'b0;
      end
    end
    #1;
    s_instr  = instr;
    s_pc     = pc;
    s_valid  = instr_valid;
    s_re     = im_re;
    s_addr   = im_addr;
    s_halted = halted;
    if (sb_en && rst_n && !stall && s_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra: got instr=%h pc=%h, expected no word", s_instr, s_pc);
      end else begin
        e = exp_q.pop_front();
        if ({s_instr, s_pc} !== e) begin
          n_err++;
          $display("FAIL sb_word: got instr=%h pc=%h, expected instr=%h pc=%h",
                   s_instr, s_pc, e[31:16], e[15:0]);
        end
      end
    end
    if (rst_n && s_re) begin
      n_cmp++;
      if (pend) begin
        n_err++;
        $display("FAIL mem_overlap: request %h while %h outstanding, expected none", s_addr, paddr);
      end
      pend  = 1'b1;
      cnt   = lat;
      paddr = s_addr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d words left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    stall  = 1'b0;
    j_ctrl = 1'b0;
    hlt    = 1'b0;
    j_pc   = 16'h0000;
    sb_en  = 1'b0;
    pend   = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (s_re !== 1'b0) begin
        n_err++;
        $display("FAIL reset_im_re: got %b, expected 0", s_re);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    lat = 1;
    do_reset();
    #1;
    n_cmp++;
    if ({instr, pc, instr_valid, halted, dbg_state} !== {16'h0000, 16'h0000, 1'b0, 1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL reset_state: got instr=%h pc=%h v=%b h=%b st=%0d, expected 0/0/0/0/0",
               instr, pc, instr_valid, halted, dbg_state);
    end
    n_cmp++;
    if ({im_re, im_addr} !== {1'b1, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_first_fetch: got re=%b addr=%h, expected re=1 addr=0000", im_re, im_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    lat = 1;
    do_reset();
    sb_en = 1'b1;
    for (int a = 0; a < 4; a++) push_exp(16'(a));
    for (int i = 0; i < 6; i++) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_rate: %0d words pending after 6 cycles, expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_slow_mem();
    int n_re = 0;
    int n_v = 0;
    int bad = 0;
    lat = 3;
    do_reset();
    sb_en = 1'b1;
    for (int a = 0; a < 3; a++) push_exp(16'(a));
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_re) n_re++;
      if (s_valid) n_v++;
      else if (s_instr !== 16'h0000) bad++;
    end
    n_cmp++;
    if (n_re != 4 || n_v != 3 || bad != 0) begin
      n_err++;
      $display("FAIL slow_mem: got re=%0d valid=%0d nonnop_bubbles=%0d, expected 4/3/0", n_re, n_v, bad);
    end
    drain(1, "slow_mem");
  endtask

  task automatic test_stall_skid();
    int bad = 0;
    lat = 1;
    do_reset();
    sb_en = 1'b1;
    for (int a = 0; a < 4; a++) push_exp(16'(a));
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (s_instr !== mem_f(16'h0000) || s_re !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL stall_hold: %0d cycles not holding A with im_re=0, expected 0", bad);
    end
    stall = 1'b0;
    step();
    step();
    n_cmp++;
    if ({s_re, s_addr} !== {1'b1, 16'h0002}) begin
      n_err++;
      $display("FAIL stall_refetch: got re=%b addr=%h, expected re=1 addr=0002", s_re, s_addr);
    end
    drain(10, "stall");
  endtask

  task automatic test_jump_outstanding();
    int n = 0;
    lat = 3;
    do_reset();
    sb_en = 1'b1;
    for (int a = 0; a < 5; a++) push_exp(16'(a));
    push_exp(16'h0040);
    while (!(pend && paddr == 16'h0005) && n < 40) begin
      step();
      n++;
    end
    n_cmp++;
    if (!(pend && paddr == 16'h0005)) begin
      n_err++;
      $display("FAIL jump_setup: fetch of 0005 not outstanding (pend=%b addr=%h)", pend, paddr);
    end
    j_ctrl = 1'b1;
    j_pc   = 16'h0040;
    step();
    j_ctrl = 1'b0;
    step();
    n_cmp++;
    if ({s_valid, s_instr} !== {1'b0, 16'h0000}) begin
      n_err++;
      $display("FAIL jump_bubble: got v=%b instr=%h, expected v=0 instr=0000", s_valid, s_instr);
    end
    drain(20, "jump");
  endtask

  task automatic test_jump_same_cycle();
    lat = 1;
    do_reset();
    sb_en = 1'b1;
    push_exp(16'h0000);
    push_exp(16'h0080);
    step();
    step();
    j_ctrl = 1'b1;
    j_pc   = 16'h0080;
    step();
    j_ctrl = 1'b0;
    drain(10, "jump_same");
  endtask

  task automatic test_halt();
    int bad = 0;
    lat = 3;
    do_reset();
    step();
    hlt    = 1'b1;
    j_ctrl = 1'b1;
    j_pc   = 16'h0040;
    step();
    hlt    = 1'b0;
    j_ctrl = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_halted !== 1'b1 || s_re !== 1'b0 || s_valid !== 1'b0 || s_instr !== 16'h0000) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL halt_hold: %0d bad cycles in HALT, expected 0", bad);
    end
    do_reset();
    sb_en = 1'b1;
    push_exp(16'h0000);
    push_exp(16'h0001);
    step();
    n_cmp++;
    if ({s_re, s_addr, s_halted} !== {1'b1, 16'h0000, 1'b0}) begin
      n_err++;
      $display("FAIL halt_restart: got re=%b addr=%h halted=%b, expected 1/0000/0", s_re, s_addr, s_halted);
    end
    drain(20, "halt_restart");
  endtask

  task automatic test_pc_wrap();
    lat = 1;
    do_reset();
    sb_en = 1'b1;
    push_exp(16'hFFFE);
    push_exp(16'hFFFF);
    push_exp(16'h0000);
    j_ctrl = 1'b1;
    j_pc   = 16'hFFFE;
    step();
    j_ctrl = 1'b0;
    step();
    n_cmp++;
    if ({s_re, s_addr} !== {1'b1, 16'hFFFE}) begin
      n_err++;
      $display("FAIL wrap_target: got re=%b addr=%h, expected re=1 addr=fffe", s_re, s_addr);
    end
    step();
    step();
    n_cmp++;
    if ({s_re, s_addr} !== {1'b1, 16'h0000}) begin
      n_err++;
      $display("FAIL wrap_next: got re=%b addr=%h, expected re=1 addr=0000", s_re, s_addr);
    end
    drain(10, "wrap");
  endtask

  initial begin
    rst_n    = 1'b0;
    stall    = 1'b0;
    j_ctrl   = 1'b0;
    j_pc     = 16'h0000;
    hlt      = 1'b0;
    im_valid = 1'b0;
    im_rdata = 16'h0000;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_slow_mem();
    test_stall_skid();
    test_jump_outstanding();
    test_jump_same_cycle();
    test_halt();
    test_pc_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
